ama_riscv_dmem_arb: RTL and testbench



---
 rtl/ama_riscv_dmem_arb_pkg.sv | 33 +++
 rtl/ama_riscv_dmem_arb_if.sv | 44 ++++
 rtl/ama_riscv_rr_arb2.sv | 46 ++++
 rtl/ama_riscv_dmem_arb.sv | 137 +++++++++++++
 tb/tb_ama_riscv_dmem_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ama_riscv_dmem_arb_pkg.sv
// Shared types and region constants for the data-memory arbiter.
// Region decode maps the two top address bits onto DMEM, MMIO or unmapped.
package ama_riscv_dmem_arb_pkg;

    localparam logic [1:0] DMEM_RANGE = 2'b00;
    localparam logic [1:0] MMIO_RANGE = 2'b01;

    typedef enum logic [1:0] {
        TGT_DMEM = 2'd0,
        TGT_MMIO = 2'd1,
        TGT_NONE = 2'd2
    } tgt_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic tgt_e region_decode(input logic [1:0] region);
        tgt_e t;
        if (region == DMEM_RANGE) begin
            t = TGT_DMEM;
        end else if (region == MMIO_RANGE) begin
            t = TGT_MMIO;
        end else begin
            t = TGT_NONE;
        end
        return t;
    endfunction

endpackage

// File: rtl/ama_riscv_dmem_arb_if.sv
// Requester-side bundle of the data-memory arbiter: two request channels and
// their response channels.
//
// Handshake: a request transfers in any cycle where reqN_valid && reqN_ready.
// The requester may hold or change its payload while not ready; nothing is
// remembered across cycles. ready never rises without valid. rspN_valid is a
// one-cycle pulse exactly one cycle after the transfer and cannot be stalled.
interface ama_riscv_dmem_arb_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic        req0_we;
    logic [3:0]  req0_wmask;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic        req1_we;
    logic [3:0]  req1_wmask;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        rsp1_err;

    modport slave (
        input  req0_valid, req0_addr, req0_we, req0_wmask, req0_wdata,
        input  req1_valid, req1_addr, req1_we, req1_wmask, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
    );

    modport master (
        output req0_valid, req0_addr, req0_we, req0_wmask, req0_wdata,
        output req1_valid, req1_addr, req1_we, req1_wmask, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
    );

endinterface

// File: rtl/ama_riscv_rr_arb2.sv
// Two-way round-robin grant. last_grant is the only state; it moves only on
// an actual grant and resets to 1 so requester 0 wins the first contention.
module ama_riscv_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_q;
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end
    end

    // No grants while reset is held, even if requesters are valid.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/ama_riscv_dmem_arb.sv
// Arbitrates core and loader requests onto DMEM / MMIO and steers the
// one-cycle-latency read data back to whichever requester owned the access.
module ama_riscv_dmem_arb
    import ama_riscv_dmem_arb_pkg::*;
#(
    parameter int DMEM_AW    = 12,
    parameter int MMIO_AW    = 6,
    parameter int REGION_LSB = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    ama_riscv_dmem_arb_if.slave  bus,

    output logic                 dmem_en,
    output logic [3:0]           dmem_we,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,

    output logic                 mmio_en,
    output logic [3:0]           mmio_we,
    output logic [MMIO_AW-1:0]   mmio_addr,
    output logic [31:0]          mmio_wdata,
    input  logic [31:0]          mmio_rdata,

    output logic                 dbg_last_grant
);

    dmem_req_t  req0;
    dmem_req_t  req1;
    dmem_req_t  sel;
    logic [1:0] valid;
    logic [1:0] grant;
    logic       any_grant;
    tgt_e       sel_tgt;

    assign req0 = '{addr: bus.req0_addr, we: bus.req0_we,
                    wmask: bus.req0_wmask, wdata: bus.req0_wdata};
    assign req1 = '{addr: bus.req1_addr, we: bus.req1_we,
                    wmask: bus.req1_wmask, wdata: bus.req1_wdata};
    assign valid = {bus.req1_valid, bus.req0_valid};

    ama_riscv_rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .grant      (grant),
        .last_grant (dbg_last_grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign any_grant      = |grant;

    assign sel     = grant[1] ? req1 : req0;
    assign sel_tgt = region_decode(sel.addr[REGION_LSB+1:REGION_LSB]);

    // Offset bits above the target's word range are dropped, so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel.addr;

    always_comb begin
        dmem_en    = 1'b0;
        dmem_we    = 4'b0000;
        dmem_addr  = sel.addr[DMEM_AW+1:2];
        dmem_wdata = sel.wdata;
        mmio_en    = 1'b0;
        mmio_we    = 4'b0000;
        mmio_addr  = sel.addr[MMIO_AW+1:2];
        mmio_wdata = sel.wdata;
        if (any_grant) begin
            case (sel_tgt)
                TGT_DMEM: begin
                    dmem_en = 1'b1;
                    dmem_we = sel.we ? sel.wmask : 4'b0000;
                end
                TGT_MMIO: begin
                    mmio_en = 1'b1;
                    mmio_we = sel.we ? sel.wmask : 4'b0000;
                end
                default: begin
                    dmem_en = 1'b0;
                    mmio_en = 1'b0;
                end
            endcase
        end
    end

    logic pend_valid;
    logic pend_owner;
    tgt_e pend_target;
    logic pend_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_owner  <= 1'b0;
            pend_target <= TGT_NONE;
            pend_we     <= 1'b0;
        end else begin
            pend_valid <= any_grant;
            if (any_grant) begin
                pend_owner  <= grant[1];
                pend_target <= sel_tgt;
                pend_we     <= sel.we;
            end
        end
    end

    // A response pending when reset arrives is dropped, not delivered.
    logic        rsp_active;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always_comb begin
        rsp_active = pend_valid && !rst;
        rsp_err    = (pend_target == TGT_NONE);
        rsp_rdata  = 32'h0;
        if (!pend_we) begin
            case (pend_target)
                TGT_DMEM: rsp_rdata = dmem_rdata;
                TGT_MMIO: rsp_rdata = mmio_rdata;
                default:  rsp_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        bus.rsp0_valid = rsp_active && !pend_owner;
        bus.rsp1_valid = rsp_active &&  pend_owner;
        bus.rsp0_rdata = bus.rsp0_valid ? rsp_rdata : 32'h0;
        bus.rsp1_rdata = bus.rsp1_valid ? rsp_rdata : 32'h0;
        bus.rsp0_err   = bus.rsp0_valid && rsp_err;
        bus.rsp1_err   = bus.rsp1_valid && rsp_err;
    end

endmodule

// File: tb/tb_ama_riscv_dmem_arb.sv
// Bench for the data-memory arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle with a transaction-level reference model.
module tb_ama_riscv_dmem_arb;

    localparam int DMEM_AW = 12;
    localparam int MMIO_AW = 6;

    typedef struct packed {
        logic        v;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } tb_req_t;

    logic               clk;
    logic               rst;
    logic               dmem_en;
    logic [3:0]         dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [31:0]        dmem_rdata;
    logic               mmio_en;
    logic [3:0]         mmio_we;
    logic [MMIO_AW-1:0] mmio_addr;
    logic [31:0]        mmio_wdata;
    logic [31:0]        mmio_rdata;
    logic               dbg_last_grant;

    ama_riscv_dmem_arb_if bus ();

    ama_riscv_dmem_arb #(
        .DMEM_AW    (DMEM_AW),
        .MMIO_AW    (MMIO_AW),
        .REGION_LSB (30)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .dmem_en        (dmem_en),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .mmio_en        (mmio_en),
        .mmio_we        (mmio_we),
        .mmio_addr      (mmio_addr),
        .mmio_wdata     (mmio_wdata),
        .mmio_rdata     (mmio_rdata),
        .dbg_last_grant (dbg_last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: who was granted last, and accepted-but-unanswered requests
    // packed as {owner, target(0 dmem/1 mmio/2 none), we}.
    int         model_last = 1;
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tb_req_t mk(input logic v, input logic [31:0] a, input logic we,
                                   input logic [3:0] m, input logic [31:0] d);
        tb_req_t q;
        q.v = v; q.addr = a; q.we = we; q.wmask = m; q.wdata = d;
        return q;
    endfunction

    function automatic tb_req_t rnd_req();
        tb_req_t q;
        q.v     = 1'($urandom_range(0, 1));
        q.addr  = {2'($urandom_range(0, 3)), 30'($urandom)};
        q.we    = 1'($urandom_range(0, 1));
        q.wmask = 4'($urandom);
        q.wdata = $urandom;
        return q;
    endfunction

    function automatic int region_of(input logic [31:0] a);
        int r;
        r = int'(a >> 30);
        return (r == 0) ? 0 : (r == 1) ? 1 : 2;
    endfunction

    // One clock cycle: drive at negedge, check 1 ns later, advance the model.
    task automatic cycle(input logic r, input tb_req_t q0, input tb_req_t q1);
        logic [31:0] drd, mrd, erd;
        logic [3:0]  p;
        logic        rv0, rv1, eer, ew, en_d, en_m;
        int          g, tgt, ptgt;
        tb_req_t     s;

        rst            = r;
        bus.req0_valid = q0.v;  bus.req0_addr = q0.addr;  bus.req0_we = q0.we;
        bus.req0_wmask = q0.wmask; bus.req0_wdata = q0.wdata;
        bus.req1_valid = q1.v;  bus.req1_addr = q1.addr;  bus.req1_we = q1.we;
        bus.req1_wmask = q1.wmask; bus.req1_wdata = q1.wdata;
        drd = $urandom;
        mrd = $urandom;
        dmem_rdata = drd;
        mmio_rdata = mrd;
        if (r) exp_q.delete();
        #1;

        rv0 = 1'b0; rv1 = 1'b0; erd = 32'h0; eer = 1'b0;
        if (!r && exp_q.size() != 0) begin
            p    = exp_q.pop_front();
            ptgt = int'(p[2:1]);
            erd  = (p[0] || ptgt == 2) ? 32'h0 : (ptgt == 0) ? drd : mrd;
            eer  = (ptgt == 2);
            if (p[3]) rv1 = 1'b1; else rv0 = 1'b1;
        end
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(rv0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(rv1));
        chk("rsp0_rdata", bus.rsp0_rdata, rv0 ? erd : 32'h0);
        chk("rsp1_rdata", bus.rsp1_rdata, rv1 ? erd : 32'h0);
        chk("rsp0_err", 32'(bus.rsp0_err), 32'(rv0 & eer));
        chk("rsp1_err", 32'(bus.rsp1_err), 32'(rv1 & eer));
        chk("last_grant", 32'(dbg_last_grant), 32'(model_last));

        g = -1;
        if (!r) begin
            if (q0.v && q1.v) g = (model_last == 0) ? 1 : 0;
            else if (q0.v)    g = 0;
            else if (q1.v)    g = 1;
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));

        s    = (g == 1) ? q1 : q0;
        tgt  = region_of(s.addr);
        ew   = s.we;
        en_d = (g >= 0) && (tgt == 0);
        en_m = (g >= 0) && (tgt == 1);
        chk("dmem_en", 32'(dmem_en), 32'(en_d));
        chk("mmio_en", 32'(mmio_en), 32'(en_m));
        chk("dmem_we", 32'(dmem_we), (en_d && ew) ? 32'(s.wmask) : 32'h0);
        chk("mmio_we", 32'(mmio_we), (en_m && ew) ? 32'(s.wmask) : 32'h0);
        if (en_d) begin
            chk("dmem_addr", 32'(dmem_addr), (s.addr >> 2) % (32'd1 << DMEM_AW));
            chk("dmem_wdata", dmem_wdata, s.wdata);
        end
        if (en_m) begin
            chk("mmio_addr", 32'(mmio_addr), (s.addr >> 2) % (32'd1 << MMIO_AW));
            chk("mmio_wdata", mmio_wdata, s.wdata);
        end

        @(posedge clk);
        if (r) model_last = 1;
        else if (g >= 0) model_last = g;
        if (g >= 0) exp_q.push_back({g[0], 2'(tgt), ew});
        @(negedge clk);
    endtask

    tb_req_t idle;

    initial begin
        idle = mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_we = 1'b0;
        bus.req0_wmask = '0;   bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_we = 1'b0;
        bus.req1_wmask = '0;   bus.req1_wdata = '0;
        dmem_rdata = '0;
        mmio_rdata = '0;
        @(negedge clk);

        // Reset held with both requesters valid: nothing may be granted.
        cycle(1'b1, mk(1'b1, 32'h100, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h200, 1'b0, 4'h0, 32'h0));
        cycle(1'b1, mk(1'b1, 32'h100, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h200, 1'b0, 4'h0, 32'h0));

        // Continuous contention right after reset: 0,1,0,1.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, mk(1'b1, 32'h100 + 32'(4 * i), 1'b0, 4'h0, 32'h0),
                        mk(1'b1, 32'h300 + 32'(4 * i), 1'b0, 4'h0, 32'h0));
        cycle(1'b0, idle, idle);

        cycle(1'b0, mk(1'b1, 32'h0000_0010, 1'b0, 4'h0, 32'h0), idle);
        cycle(1'b0, idle, idle);
        cycle(1'b0, idle, mk(1'b1, 32'h4000_0008, 1'b1, 4'b0011, 32'h1234_5678));
        cycle(1'b0, idle, idle);
        cycle(1'b0, mk(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0), idle);
        cycle(1'b0, idle, idle);
        cycle(1'b0, mk(1'b1, 32'h0000_4004, 1'b0, 4'h0, 32'h0), idle);
        cycle(1'b0, idle, idle);

        // Grant, then reset the next cycle: the response must be dropped.
        cycle(1'b0, idle, mk(1'b1, 32'h0000_0020, 1'b1, 4'hF, 32'hCAFE_F00D));
        cycle(1'b1, mk(1'b1, 32'h40, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h44, 1'b0, 4'h0, 32'h0));
        cycle(1'b0, mk(1'b1, 32'h40, 1'b0, 4'h0, 32'h0), mk(1'b1, 32'h44, 1'b0, 4'h0, 32'h0));
        cycle(1'b0, idle, idle);

        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 39) == 0), rnd_req(), rnd_req());
        cycle(1'b0, idle, idle);
        cycle(1'b0, idle, idle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
